// File: rtl/button_input_conditioner.sv
// rtl/button_input_conditioner.sv - synchronise, debounce and edge-detect devboard push buttons
//
// Conditions the inverted-and-corrected push-button pins before they reach the
// core's port E input word. Each button is handled independently:
// synchroniser chain -> debounce counter -> registered level, press/release
// pulses and a sticky press flag that the core can clear.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous, active-high reset
//   buttonRaw       active-high button levels, asynchronous to clock
//   eventClear      per-bit request to clear the sticky press flag
//   buttonStable    debounced button level
//   buttonPressed   one-cycle pulse on a debounced 0->1 change
//   buttonReleased  one-cycle pulse on a debounced 1->0 change
//   pressSticky     set by a press, held until cleared
//   portWord        [7:0]=buttonStable, [15:8]=pressSticky, [31:16]=0

module button_input_conditioner #(
    parameter int NUM_BUTTONS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttonRaw,
    input  logic [NUM_BUTTONS-1:0] eventClear,
    output logic [NUM_BUTTONS-1:0] buttonStable,
    output logic [NUM_BUTTONS-1:0] buttonPressed,
    output logic [NUM_BUTTONS-1:0] buttonReleased,
    output logic [NUM_BUTTONS-1:0] pressSticky,
    output logic [31:0]            portWord
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]          count_q [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] synced;
    logic [NUM_BUTTONS-1:0] accept;

    assign synced = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; stage 0 samples the raw asynchronous pins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= buttonRaw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A change is accepted on the edge where the disagreement has persisted
    // for DEBOUNCE_CYCLES consecutive edges (counter already at the last value).
    always_comb begin
        accept = '0;
        for (int b = 0; b < NUM_BUTTONS; b++) begin
            accept[b] = (synced[b] != buttonStable[b]) && (count_q[b] == CNT_LAST);
        end
    end

    // Any agreement restarts the count, so a glitch shorter than the window is
    // dropped; acceptance also restarts it, so the counter never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                count_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                if ((synced[b] == buttonStable[b]) || accept[b]) begin
                    count_q[b] <= '0;
                end else begin
                    count_q[b] <= count_q[b] + CW'(1);
                end
            end
        end
    end

    // Level, pulses and sticky flag all update on the accepting edge, so the
    // pulse coincides with the first cycle the new level is visible.
    // A press accepted on the same edge as a clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buttonStable   <= '0;
            buttonPressed  <= '0;
            buttonReleased <= '0;
            pressSticky    <= '0;
        end else begin
            buttonStable   <= (buttonStable & ~accept) | (synced & accept);
            buttonPressed  <= accept & synced;
            buttonReleased <= accept & ~synced;
            pressSticky    <= (pressSticky & ~eventClear) | (accept & synced);
        end
    end

    always_comb begin
        portWord                    = '0;
        portWord[NUM_BUTTONS-1:0]   = buttonStable;
        portWord[8 +: NUM_BUTTONS]  = pressSticky;
    end

endmodule
